mem_arbiter: RTL and testbench

//  Single-port memory controller directly downstream of the caches block.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fetches and dcache loads/stores, data-first with a fetch starvation guard.
// Optional MEM_ARB_STATS_EN adds per-side completion counters igrant_cnt/dgrant_cnt.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] igrant_cnt,
  output logic [31:0] dgrant_cnt
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic        d_req;
  logic        ram_done;
  logic [31:0] ram_word;
  logic        starved;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
  assign ram_word = (ramstate == RAM_ERROR) ? ERR_WORD : ramload;
  assign starved  = iREN && (starve_cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    case (state_q)
      IDLE: begin
        if (d_req && !starved) state_d = DGRANT;
        else if (iREN)         state_d = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = !dWEN;
          if (ram_done) begin
            dwait   = 1'b0;
            dload   = ram_word;
            state_d = IDLE;
            // Count data wins only while a fetch is actually waiting.
            if (!iREN)
              starve_cnt_d = '0;
            else if (starve_cnt_q != CW'(STARVE_LIMIT))
              starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait        = 1'b0;
            iload        = ram_word;
            state_d      = IDLE;
            starve_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] igrant_cnt_q, igrant_cnt_d;
  logic [31:0] dgrant_cnt_q, dgrant_cnt_d;

  always_comb begin
    igrant_cnt_d = igrant_cnt_q + 32'((state_q == IGRANT) && iREN && ram_done);
    dgrant_cnt_d = dgrant_cnt_q + 32'((state_q == DGRANT) && d_req && ram_done);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      igrant_cnt_q <= '0;
      dgrant_cnt_q <= '0;
    end else begin
      igrant_cnt_q <= igrant_cnt_d;
      dgrant_cnt_q <= dgrant_cnt_d;
    end
  end

  assign igrant_cnt = igrant_cnt_q;
  assign dgrant_cnt = dgrant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural owner/queue model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] igrant_cnt, dgrant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARB_STATS_EN
    , .igrant_cnt(igrant_cnt), .dgrant_cnt(dgrant_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: who owns the RAM port (0 none, 1 data, 2 instr),
  // how many data wins a waiting fetch has suffered, and completion totals.
  int          m_owner = 0;
  int          m_starve = 0;
  int unsigned m_icomp = 0;
  int unsigned m_dcomp = 0;

  function automatic bit ram_answers(input logic [1:0] rs);
    return (rs == 2'd2) || (rs == 2'd3);
  endfunction

  function automatic logic [31:0] ram_word(input logic [1:0] rs, input logic [31:0] ld);
    return (rs == 2'd3) ? 32'hBAD1BAD1 : ld;
  endfunction

  always @(posedge CLK) begin
    if (!nRST) begin
      m_owner = 0; m_starve = 0; m_icomp = 0; m_dcomp = 0;
    end else if (m_owner == 0) begin
      if ((dREN || dWEN) && !(iREN && m_starve == LIMIT)) m_owner = 1;
      else if (iREN) m_owner = 2;
    end else if (m_owner == 1) begin
      if (!(dREN || dWEN)) m_owner = 0;
      else if (ram_answers(ramstate)) begin
        m_owner = 0;
        m_dcomp++;
        m_starve = iREN ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end
    end else begin
      if (!iREN) m_owner = 0;
      else if (ram_answers(ramstate)) begin
        m_owner = 0;
        m_icomp++;
        m_starve = 0;
      end
    end
  end

  always @(negedge CLK) begin : compare
    logic        e_ren, e_wen, e_iw, e_dw, chk_addr, done;
    logic [31:0] e_addr, e_st, e_il, e_dl;
    if (cmp_en) begin
      done = ram_answers(ramstate);
      e_ren = 0; e_wen = 0; e_addr = 0; e_st = 0;
      e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0; chk_addr = 1;
      if (m_owner == 1) begin
        if (dREN || dWEN) begin
          e_wen = dWEN; e_ren = !dWEN; e_addr = daddr; e_st = dstore;
          if (done) begin e_dw = 0; e_dl = ram_word(ramstate, ramload); end
        end else chk_addr = 0;
      end else if (m_owner == 2) begin
        if (iREN) begin
          e_ren = 1; e_addr = iaddr;
          if (done) begin e_iw = 0; e_il = ram_word(ramstate, ramload); end
        end else chk_addr = 0;
      end
      check("m_ramREN", {31'd0, ramREN}, {31'd0, e_ren});
      check("m_ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
      check("m_iwait", {31'd0, iwait}, {31'd0, e_iw});
      check("m_dwait", {31'd0, dwait}, {31'd0, e_dw});
      if (chk_addr) begin
        check("m_ramaddr", ramaddr, e_addr);
        check("m_ramstore", ramstore, e_st);
      end
      if (!e_iw || m_owner == 0) check("m_iload", iload, e_il);
      if (!e_dw || m_owner == 0) check("m_dload", dload, e_dl);
`ifdef MEM_ARB_STATS_EN
      check("m_igrant_cnt", igrant_cnt, m_icomp);
      check("m_dgrant_cnt", dgrant_cnt, m_dcomp);
`endif
    end
  end

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    tick();
    nRST = 1;
  endtask

  logic [11:0] dlow, ilow;

  initial begin
    idle_inputs();
    nRST = 0;
    tick();
    tick();
    cmp_en = 1;

    // Reset state, then five quiet cycles
    @(negedge CLK);
    check("rst_ramREN", {31'd0, ramREN}, 32'd0);
    check("rst_iwait", {31'd0, iwait}, 32'd1);
    check("rst_dload", dload, 32'd0);
    @(posedge CLK); #1;
    nRST = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("quiet_en", {30'd0, ramREN, ramWEN}, 32'd0);
      check("quiet_waits", {30'd0, iwait, dwait}, 32'd3);
      tick();
    end

    // Fetch with two BUSY cycles
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
    @(negedge CLK); check("f_c0_ren", {31'd0, ramREN}, 32'd0);
    tick();
    @(negedge CLK); check("f_c1_ren", {31'd0, ramREN}, 32'd1);
    check("f_c1_addr", ramaddr, 32'h40);
    check("f_c1_iwait", {31'd0, iwait}, 32'd1);
    tick();
    @(negedge CLK); check("f_c2_iwait", {31'd0, iwait}, 32'd1);
    tick();
    ramstate = 2'd2; ramload = 32'h8C220004;
    @(negedge CLK); check("f_c3_iwait", {31'd0, iwait}, 32'd0);
    check("f_c3_iload", iload, 32'h8C220004);
    tick();
    iREN = 0; ramstate = 2'd0;
    @(negedge CLK); check("f_c4_idle", {31'd0, ramREN}, 32'd0);
    tick();

    // Simultaneous fetch and store: store first, fetch after one idle cycle
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hCAFE; ramstate = 2'd2;
    ramload = 32'h12345678;
    @(negedge CLK); check("s_c0_wen", {31'd0, ramWEN}, 32'd0);
    tick();
    @(negedge CLK);
    check("s_c1_en", {30'd0, ramREN, ramWEN}, 32'd1);
    check("s_c1_addr", ramaddr, 32'h100);
    check("s_c1_store", ramstore, 32'hCAFE);
    check("s_c1_waits", {30'd0, iwait, dwait}, 32'd2);
    tick();
    dWEN = 0;
    @(negedge CLK); check("s_c2_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    tick();
    @(negedge CLK);
    check("s_c3_ren", {31'd0, ramREN}, 32'd1);
    check("s_c3_addr", ramaddr, 32'h44);
    check("s_c3_iwait", {31'd0, iwait}, 32'd0);
    check("s_c3_iload", iload, 32'h12345678);
    tick();
    iREN = 0;

    // Starvation guard: four data completions, then the fetch, then data again
    do_reset();
    iREN = 1; dREN = 1; ramstate = 2'd2; iaddr = 32'h80; daddr = 32'h200;
    dlow = '0; ilow = '0;
    for (int k = 0; k < 12; k++) begin
      ramload = $urandom;
      @(negedge CLK);
      dlow[k] = !dwait;
      ilow[k] = !iwait;
      tick();
    end
    check("starve_dlow", {20'd0, dlow}, 32'h8AA);
    check("starve_ilow", {20'd0, ilow}, 32'h200);
    dREN = 0; iREN = 0;

    // Withdrawn read, then an ERROR on a fetch
    do_reset();
    dREN = 1; daddr = 32'h200; ramstate = 2'd1;
    tick();
    @(negedge CLK);
    check("w_c1_ren", {31'd0, ramREN}, 32'd1);
    check("w_c1_dwait", {31'd0, dwait}, 32'd1);
    tick();
    dREN = 0;
    @(negedge CLK);
    check("w_c2_ren", {31'd0, ramREN}, 32'd0);
    check("w_c2_dwait", {31'd0, dwait}, 32'd1);
    tick();
    dREN = 1;
    @(negedge CLK); check("w_c3_idle", {31'd0, ramREN}, 32'd0);
    tick();
    ramstate = 2'd2;
    @(negedge CLK); check("w_c4_dwait", {31'd0, dwait}, 32'd0);
    tick();
    dREN = 0; iREN = 1; iaddr = 32'h80;
    tick();
    ramstate = 2'd3; ramload = 32'h0;
    @(negedge CLK);
    check("e_iwait", {31'd0, iwait}, 32'd0);
    check("e_iload", iload, 32'hBAD1BAD1);
    check("e_dwait", {31'd0, dwait}, 32'd1);
    tick();
    iREN = 0; ramstate = 2'd0;

    // Reset asserted while a store is granted
    do_reset();
    dWEN = 1; daddr = 32'h300; dstore = 32'h55; ramstate = 2'd1;
    tick();
    @(negedge CLK); check("r_c1_wen", {31'd0, ramWEN}, 32'd1);
    nRST = 0;
    tick();
    @(negedge CLK);
    check("r_en", {30'd0, ramREN, ramWEN}, 32'd0);
    check("r_addr", ramaddr, 32'd0);
    check("r_store", ramstore, 32'd0);
    check("r_dwait", {31'd0, dwait}, 32'd1);
    tick();
    nRST = 1; dWEN = 0;

`ifdef MEM_ARB_STATS_EN
    do_reset();
    ramstate = 2'd2;
    iREN = 1;
    for (int k = 0; k < 3; k++) begin tick(); tick(); end
    iREN = 0; dWEN = 1;
    for (int k = 0; k < 2; k++) begin tick(); tick(); end
    dWEN = 0;
    tick();
    @(negedge CLK);
    check("stats_i", igrant_cnt, 32'd3);
    check("stats_d", dgrant_cnt, 32'd2);
    tick();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0) iREN = ~iREN;
      if ($urandom_range(0, 7) == 0) dREN = ~dREN;
      if ($urandom_range(0, 9) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      case ($urandom_range(0, 9))
        0:             ramstate = 2'd0;
        1, 2, 3:       ramstate = 2'd1;
        9:             ramstate = 2'd3;
        default:       ramstate = 2'd2;
      endcase
      nRST = ($urandom_range(0, 199) != 0);
      tick();
    end
    nRST = 1;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
